// File: rtl/cpu_bus_pkg.sv
// Shared types and default constants for the CPU bus controller slice.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    REGION_RAM = 2'd0,
    REGION_ROM = 2'd1,
    REGION_IO  = 2'd2
  } region_t;

  localparam logic [15:0] IO_BASE_DEF  = 16'h8400;
  localparam int          ROM_BITS_DEF = 5;
  localparam int          IO_IDX_W     = 4;

endpackage

// File: rtl/cpu_bus_decode.sv
// Combinational CPU address decode: ROM has priority over the IO window, everything else is RAM.
module cpu_bus_decode
  import cpu_bus_pkg::*;
#(
  parameter int          NUM_IO   = 2,
  parameter logic [15:0] IO_BASE  = IO_BASE_DEF,
  parameter int          ROM_BITS = ROM_BITS_DEF
) (
  input  logic [15:0]         addr,
  output region_t             region,
  output logic [IO_IDX_W-1:0] io_idx
);

  logic        rom_hit;
  logic        io_hit;
  logic [16:0] io_off;

  assign rom_hit = &addr[15 -: ROM_BITS];

  // 17-bit offset: an address below IO_BASE borrows into bit 16 and so never lands in the window
  assign io_off = {1'b0, addr} - {1'b0, IO_BASE};
  assign io_hit = io_off < 17'(NUM_IO);
  assign io_idx = io_off[IO_IDX_W-1:0];

  always_comb begin
    region = REGION_RAM;
    if (rom_hit) begin
      region = REGION_ROM;
    end else if (io_hit) begin
      region = REGION_IO;
    end
  end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU bus controller: divided CPU clock, stretched CPU reset, read-data capture,
// IO output ports and RAM write strobe, all in the clk domain.
module cpu_bus_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int          CPU_DIV_W      = 3,
  parameter int          NUM_IO         = 2,
  parameter logic [15:0] IO_BASE        = IO_BASE_DEF,
  parameter int          ROM_BITS       = ROM_BITS_DEF,
  parameter int          CPU_RST_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                cpu_clk,
  output logic                cpu_reset,
  input  logic [15:0]         cpu_addr,
  input  logic [7:0]          cpu_dout,
  input  logic                cpu_we,
  output logic [7:0]          cpu_din,
  input  logic [7:0]          rom_data,
  input  logic [7:0]          ram_data,
  output logic                ram_we,
  output logic                rom_sel,
  output logic [NUM_IO*8-1:0] io_port
);

  localparam logic [CPU_DIV_W-1:0] RISE_AT  = {1'b0, {(CPU_DIV_W-1){1'b1}}};
  localparam logic [7:0]           RST_LAST = 8'(CPU_RST_CYCLES - 1);

  logic [CPU_DIV_W-1:0] div_ctr;
  logic                 rise_evt;
  logic                 fall_evt;
  region_t              region;
  logic [IO_IDX_W-1:0]  io_idx;
  logic [7:0]           io_regs [NUM_IO];
  logic [7:0]           io_rd;
  logic [7:0]           rst_ctr;
  logic                 io_wr;

  cpu_bus_decode #(
    .NUM_IO   (NUM_IO),
    .IO_BASE  (IO_BASE),
    .ROM_BITS (ROM_BITS)
  ) u_decode (
    .addr   (cpu_addr),
    .region (region),
    .io_idx (io_idx)
  );

  assign rise_evt = (div_ctr == RISE_AT);
  assign fall_evt = (div_ctr == '1);
  assign cpu_clk  = div_ctr[CPU_DIV_W-1];
  assign rom_sel  = (region == REGION_ROM);
  assign io_wr    = fall_evt && cpu_we && (region == REGION_IO);

  always_comb begin
    io_rd = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      if (io_idx == IO_IDX_W'(i)) io_rd = io_regs[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_ctr <= '0;
    end else begin
      div_ctr <= div_ctr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_din <= '0;
    end else if (rise_evt) begin
      case (region)
        REGION_ROM: cpu_din <= rom_data;
        REGION_IO:  cpu_din <= io_rd;
        default:    cpu_din <= ram_data;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_IO; i++) io_regs[i] <= '0;
    end else if (io_wr) begin
      for (int i = 0; i < NUM_IO; i++) begin
        if (io_idx == IO_IDX_W'(i)) io_regs[i] <= cpu_dout;
      end
    end
  end

  // Strobe is registered on the fall edge, so it lasts exactly one clk and clears itself
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_we <= 1'b0;
    end else begin
      ram_we <= fall_evt && cpu_we && (region == REGION_RAM);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_reset <= 1'b1;
      rst_ctr   <= '0;
    end else if (cpu_reset && fall_evt) begin
      rst_ctr <= rst_ctr + 1'b1;
      if (rst_ctr == RST_LAST) cpu_reset <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_IO; g++) begin : g_io_port
    assign io_port[8*g +: 8] = io_regs[g];
  end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed self-checking bench for cpu_bus_ctrl at default parameters; read data is
// predicted at drive time into a scoreboard queue and checked at the rise event.
module tb_cpu_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_clk;
  logic        cpu_reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic [7:0]  cpu_din;
  logic [7:0]  rom_data;
  logic [7:0]  ram_data;
  logic        ram_we;
  logic        rom_sel;
  logic [15:0] io_port;

  int checks   = 0;
  int failures = 0;

  localparam int R_RAM = 0;
  localparam int R_ROM = 1;
  localparam int R_IO  = 2;

  logic [7:0] sb [$];
  logic [7:0] mport [2];

  cpu_bus_ctrl #(
    .CPU_DIV_W      (3),
    .NUM_IO         (2),
    .IO_BASE        (16'h8400),
    .ROM_BITS       (5),
    .CPU_RST_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_clk   (cpu_clk),
    .cpu_reset (cpu_reset),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_we    (cpu_we),
    .cpu_din   (cpu_din),
    .rom_data  (rom_data),
    .ram_data  (ram_data),
    .ram_we    (ram_we),
    .rom_sel   (rom_sel),
    .io_port   (io_port)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mregion(input logic [15:0] a);
    if (a >= 16'hF800) return R_ROM;
    if (a == 16'h8400 || a == 16'h8401) return R_IO;
    return R_RAM;
  endfunction

  // One full CPU cycle starting just after a fall event, followed by an idle cycle
  task automatic cpu_cycle(input logic [15:0] addr, input logic we, input logic [7:0] dout);
    int         rg;
    logic [7:0] exp_din;
    rg = mregion(addr);
    cpu_addr = addr;
    cpu_we   = we;
    cpu_dout = dout;
    sb.push_back(rg == R_ROM ? rom_data : (rg == R_IO ? mport[addr[0]] : ram_data));
    #1;
    check("rom_sel", rom_sel, (rg == R_ROM));
    repeat (4) tick();
    check("cpu_clk_rise", cpu_clk, 1'b1);
    exp_din = sb.pop_front();
    check("cpu_din_rise", cpu_din, exp_din);
    if (we && rg == R_IO) mport[addr[0]] = dout;
    repeat (4) tick();
    check("cpu_clk_fall", cpu_clk, 1'b0);
    check("ram_we_fall", ram_we, (we && rg == R_RAM));
    check("io_port_fall", io_port, {mport[1], mport[0]});
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
    tick();
    check("ram_we_single", ram_we, 1'b0);
    repeat (2) tick();
    check("cpu_din_hold", cpu_din, exp_din);
    repeat (5) tick();
  endtask

  // Release reset and follow cpu_clk / cpu_reset for the 32 clk of the reset stretch
  task automatic release_and_check(input logic io_write);
    @(negedge clk);
    reset = 1'b0;
    if (io_write) begin
      cpu_addr = 16'h8400;
      cpu_dout = 8'h11;
      cpu_we   = 1'b1;
    end
    for (int k = 1; k <= 32; k++) begin
      tick();
      check("cpu_clk_wave", cpu_clk, ((k % 8) >= 4));
      check("cpu_reset_stretch", cpu_reset, (k < 32));
      if (io_write && k == 8) begin
        mport[0] = 8'h11;
        check("io_write_in_reset", io_port, {mport[1], mport[0]});
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
      end
    end
  endtask

  initial begin
    int pulses;
    reset    = 1'b1;
    cpu_addr = 16'h0000;
    cpu_dout = 8'h00;
    cpu_we   = 1'b0;
    rom_data = 8'hA9;
    ram_data = 8'h33;
    mport[0] = 8'h00;
    mport[1] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_clk", cpu_clk, 1'b0);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_cpu_din", cpu_din, 8'h00);
    check("rst_io_port", io_port, 16'h0000);
    check("rst_ram_we", ram_we, 1'b0);

    release_and_check(1'b0);

    cpu_cycle(16'hF800, 1'b0, 8'h00);
    cpu_cycle(16'h8401, 1'b1, 8'h5A);
    cpu_cycle(16'h8401, 1'b0, 8'h00);
    cpu_cycle(16'h8400, 1'b1, 8'h3C);
    cpu_cycle(16'h8400, 1'b0, 8'h00);
    ram_data = 8'hC7;
    cpu_cycle(16'h0200, 1'b1, 8'h66);
    cpu_cycle(16'h83FF, 1'b0, 8'h00);
    rom_data = 8'h4E;
    cpu_cycle(16'hFFFC, 1'b1, 8'h99);
    cpu_cycle(16'h8402, 1'b1, 8'h21);

    // Held RAM write over two CPU cycles gives one strobe per cycle
    cpu_addr = 16'h0200;
    cpu_we   = 1'b1;
    pulses   = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (ram_we === 1'b1) pulses++;
    end
    check("ram_we_pulses", pulses, 2);
    cpu_we = 1'b0;
    tick();
    check("ram_we_pulse_end", ram_we, 1'b0);
    repeat (7) tick();

    // Write enable raised then dropped between events must not write
    tick();
    cpu_addr = 16'h8400;
    cpu_dout = 8'h77;
    cpu_we   = 1'b1;
    repeat (4) tick();
    cpu_we = 1'b0;
    repeat (3) tick();
    check("late_we_io_port", io_port, {mport[1], mport[0]});
    check("late_we_ram_we", ram_we, 1'b0);

    // Address moved from IO to RAM before the fall event: RAM write, no port change
    cpu_addr = 16'h8401;
    cpu_dout = 8'hEE;
    cpu_we   = 1'b1;
    repeat (5) tick();
    cpu_addr = 16'h0300;
    repeat (3) tick();
    check("addr_move_ram_we", ram_we, 1'b1);
    check("addr_move_io_port", io_port, {mport[1], mport[0]});
    cpu_we = 1'b0;
    tick();
    check("addr_move_ram_we_end", ram_we, 1'b0);
    repeat (7) tick();

    // Reset during the strobe cycle
    cpu_addr = 16'h0200;
    cpu_we   = 1'b1;
    repeat (8) tick();
    check("abort_ram_we_pre", ram_we, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_ram_we", ram_we, 1'b0);
    check("abort_io_port", io_port, 16'h0000);
    check("abort_cpu_din", cpu_din, 8'h00);
    check("abort_cpu_reset", cpu_reset, 1'b1);
    check("abort_cpu_clk", cpu_clk, 1'b0);
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
    mport[0] = 8'h00;
    mport[1] = 8'h00;

    release_and_check(1'b1);
    cpu_cycle(16'h8400, 1'b0, 8'h00);
    cpu_cycle(16'h8401, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_bus_ctrl.md
CPU_BUS_CTRL -- requirements
Module: cpu_bus_ctrl

Interface
REQ-001 SHALL have parameter CPU_DIV_W, default 3: divider width; cpu_clk period = 2^CPU_DIV_W clk cycles; legal 2..8.
REQ-002 SHALL have parameter NUM_IO, default 2: number of 8-bit output ports; legal 1..16.
REQ-003 SHALL have parameter IO_BASE, default 16'h8400: address of io port 0; port i at IO_BASE+i.
REQ-004 SHALL have parameter ROM_BITS, default 5: ROM region = addresses whose top ROM_BITS bits are all ones.
REQ-005 SHALL have parameter CPU_RST_CYCLES, default 4: cpu_clk periods cpu_reset is held after reset release; legal 1..255.
REQ-006 SHALL have ports: clk  in  1  system clock, sole clock domain.
REQ-007 SHALL have ports: reset  in  1  asynchronous, active-high system reset.
REQ-008 SHALL have ports: cpu_clk  out  1  derived CPU clock; cpu_reset  out  1  CPU reset.
REQ-009 SHALL have ports: cpu_addr  in  16, cpu_dout  in  8, cpu_we  in  1  CPU address, write data, write enable.
REQ-010 SHALL have ports: cpu_din  out  8  registered CPU read data.
REQ-011 SHALL have ports: rom_data  in  8, ram_data  in  8  memory read data; ram_we  out  1  RAM write strobe; rom_sel  out  1  combinational ROM decode.
REQ-012 SHALL have ports: io_port  out  NUM_IO*8  port i on bits [8i+7:8i].

Function
REQ-013 SHALL hold a CPU_DIV_W-bit counter div_ctr, incrementing every clk, wrapping all-ones to 0; cpu_clk = div_ctr MSB.
REQ-014 Rise event SHALL be the clk edge where div_ctr goes 2^(CPU_DIV_W-1)-1 -> 2^(CPU_DIV_W-1); fall event the edge where it wraps to 0.
REQ-015 Decode SHALL be priority ROM, then IO (IO_BASE <= addr < IO_BASE+NUM_IO), else RAM.
REQ-016 On each rise event cpu_din SHALL load rom_data (ROM), io_port[i] (IO, i = addr-IO_BASE) or ram_data (RAM); cpu_din is otherwise held.
REQ-017 On a fall event with cpu_we=1 and IO decode, io_port[i] SHALL load cpu_dout; other ports unchanged.
REQ-018 ram_we SHALL be high for exactly one clk cycle, starting at a fall event where cpu_we=1 and decode is RAM; never otherwise.
REQ-019 Writes decoding to ROM SHALL have no effect (no ram_we, no port change).
REQ-020 cpu_we or cpu_addr changes between events SHALL have no effect; only values at event edges matter.
REQ-021 cpu_reset SHALL be high while reset is high and until CPU_RST_CYCLES fall events have occurred after release; it SHALL deassert on that fall event edge and stay low until next reset.
REQ-022 While cpu_reset is high, IO writes and ram_we SHALL still follow REQ-017/018 (CPU drives cpu_we=0 in reset).

Reset
REQ-023 On reset assertion, asynchronously: div_ctr=0, cpu_clk=0, cpu_din=8'h00, all io_port=0, ram_we=0, cpu_reset=1, reset-stretch counter=0.
REQ-024 Reset asserted mid-write SHALL abort it: ram_we drops immediately; no port update.

Structure
REQ-025 Shared package cpu_bus_pkg SHALL hold the region enum (REGION_RAM, REGION_ROM, REGION_IO) and default constants for IO_BASE, ROM_BITS.
REQ-026 Address decode SHALL be a combinational sub-module cpu_bus_decode (addr -> region, io index); all state lives in cpu_bus_ctrl.

Verification (CPU_DIV_W=3, NUM_IO=2, IO_BASE=16'h8400, ROM_BITS=5, CPU_RST_CYCLES=4)
REQ-027 Release reset -> cpu_clk period 8 clk, 4 high/4 low; cpu_reset falls on 4th fall event (32 clk after release).
REQ-028 cpu_addr=16'hF800, rom_data=8'hA9 at rise event -> rom_sel=1, cpu_din=8'hA9 same edge cpu_clk rises; ram_data ignored.
REQ-029 cpu_we=1, addr=16'h8401, dout=8'h5A at fall event -> io_port[15:8]=8'h5A, io_port[7:0] unchanged, ram_we stays 0; subsequent read of 16'h8401 -> cpu_din=8'h5A.
REQ-030 cpu_we=1, addr=16'h0200 -> ram_we high exactly 1 clk after fall event, once per CPU cycle; addr=16'hFFFC write -> no ram_we.
REQ-031 Assert reset during ram_we cycle -> ram_we, io_port, cpu_din return to 0 asynchronously; cpu_reset re-asserts.
